// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port SRAM among N_REQ requesters.
// After reset it optionally zero-fills the whole array before opening the request ports.
module sram_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int INIT_EN    = 1,
    localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BEW       = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_vld,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [N_REQ*BEW-1:0]        req_wbe,
    output logic                        rsp_vld,
    output logic [IDW-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        mem_en,
    output logic                        mem_wr_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wr_data,
    output logic [BEW-1:0]              mem_wr_byte_en,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data,
    output logic                        init_done
);

    localparam int CW = IDW + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  init_done_q;
    logic [IDW-1:0]        ptr_q;
    logic                  rsp_vld_q;
    logic [IDW-1:0]        rsp_id_q;

    logic [ADDR_WIDTH-1:0] addr_a  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [N_REQ];
    logic [BEW-1:0]        wbe_a   [N_REQ];

    logic                  any_vld;
    logic [IDW-1:0]        win_id;
    logic                  grant;
    logic [IDW-1:0]        ptr_d;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign wbe_a[gi]   = req_wbe[gi*BEW +: BEW];
    end

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        logic [CW-1:0] cand;
        cand    = '0;
        any_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!any_vld && req_vld[cand[IDW-1:0]]) begin
                any_vld = 1'b1;
                win_id  = cand[IDW-1:0];
            end
        end
    end

    // Gating with rst_n keeps the SRAM and the ports quiet while reset is held.
    assign grant = rst_n && (state_q == ST_RUN) && any_vld;
    assign ptr_d = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;

    always_comb begin
        req_rdy = '0;
        if (grant) begin
            req_rdy[win_id] = 1'b1;
        end
    end

    always_comb begin
        mem_en         = 1'b0;
        mem_wr_en      = 1'b0;
        mem_addr       = '0;
        mem_wr_data    = '0;
        mem_wr_byte_en = '0;
        if (rst_n && (state_q == ST_INIT)) begin
            mem_en         = 1'b1;
            mem_wr_en      = 1'b1;
            mem_addr       = init_addr_q;
            mem_wr_byte_en = '1;
        end else if (grant) begin
            mem_en         = 1'b1;
            mem_wr_en      = req_wr[win_id];
            mem_addr       = addr_a[win_id];
            mem_wr_data    = wdata_a[win_id];
            mem_wr_byte_en = wbe_a[win_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_addr_q <= '0;
            init_done_q <= (INIT_EN == 0);
            ptr_q       <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rsp_vld_q <= 1'b0;
                    if (init_addr_q == '1) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rsp_vld_q <= grant && !req_wr[win_id];
                    if (grant) begin
                        ptr_q <= ptr_d;
                        if (!req_wr[win_id]) begin
                            rsp_id_q <= win_id;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign rsp_vld   = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = mem_rd_data;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: behavioural SRAM, reference memory and a
// response scoreboard filled when grants are expected and drained as rsp_* appears.
module tb_sram_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 9;
    localparam int DW  = 128;
    localparam int BW  = DW / 8;
    localparam int IDW = 2;
    localparam int DEPTH = 2 ** AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_vld;
    logic [N-1:0]      req_rdy;
    logic [N-1:0]      req_wr;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*BW-1:0]   req_wbe;
    logic              rsp_vld;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              mem_en;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wr_data;
    logic [BW-1:0]     mem_wr_byte_en;
    logic [DW-1:0]     mem_rd_data;
    logic              init_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } rsp_t;

    rsp_t          sb_q[$];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] sram    [DEPTH];
    logic          prefill;

    sram_port_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wbe(req_wbe),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en),
        .mem_rd_data(mem_rd_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM; prefilled with garbage so the zero sweep is observable.
    always @(posedge clk) begin
        if (prefill) begin
            for (int a = 0; a < DEPTH; a++) begin
                sram[a] <= {4{32'hDEAD_0000 | 32'(a)}};
            end
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_wr_byte_en[b]) sram[mem_addr][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
                end
            end else begin
                mem_rd_data <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_vld[i]              = 1'b1;
        req_wr[i]               = wr;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
        req_wbe[i*BW +: BW]     = be;
    endtask

    task automatic clear_all();
        req_vld = '0;
    endtask

    task automatic chk_init(input string tag, input int i);
        chk(tag, 256'({mem_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_byte_en, req_rdy, init_done}),
                 256'({1'b1, 1'b1, AW'(i), {DW{1'b0}}, {BW{1'b1}}, 4'b0000, 1'b0}));
    endtask

    // One arbitration cycle: checks the response owed by the previous cycle,
    // the grant vector, and records what the granted access should produce.
    task automatic cycle(input int exp_win, input string tag);
        logic [N-1:0]   exp_rdy;
        logic [IDW-1:0] wi;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [BW-1:0]  be;
        rsp_t           e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, " rsp"}, 256'({rsp_vld, rsp_id, rsp_data}), 256'({1'b1, e.id, e.data}));
        end else begin
            chk({tag, " rsp_idle"}, 256'(rsp_vld), 256'(1'b0));
        end
        exp_rdy = (exp_win >= 0) ? (4'b0001 << exp_win) : 4'b0000;
        chk({tag, " rdy"}, 256'(req_rdy), 256'(exp_rdy));
        $display("cycle %s: rdy=%b expected winner=%0d rsp_vld=%b rsp_id=%0d", tag, req_rdy, exp_win, rsp_vld, rsp_id);
        if (exp_win >= 0) begin
            wi = exp_win[IDW-1:0];
            a  = req_addr[exp_win*AW +: AW];
            d  = req_wdata[exp_win*DW +: DW];
            be = req_wbe[exp_win*BW +: BW];
            if (req_wr[wi]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[b]) exp_mem[a][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                e.id   = wi;
                e.data = exp_mem[a];
                sb_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wbe = '0;
        prefill = 1'b1;
        rst_n   = 1'b0;
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        repeat (2) @(negedge clk);
        prefill = 1'b0;
        // All requesters reading distinct top addresses; they must wait out reset and INIT.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(DEPTH - 1 - i), '0, '0);
        #1 chk("reset", 256'({mem_en, mem_wr_en, req_rdy, rsp_vld, rsp_id, init_done}), 256'(0));

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1 chk_init("init_partial", i);
            @(negedge clk);
        end
        #1 chk("init_at_100", 256'(mem_addr), 256'(100));
        rst_n = 1'b0;
        #1 chk("init_rst_quiet", 256'({mem_en, mem_wr_en, req_rdy}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            #1 chk_init("init_sweep", i);
            @(negedge clk);
        end
        #1 chk("init_done_rise", 256'(init_done), 256'(1'b1));

        // Round-robin over all four, first grant in the init_done cycle.
        for (int c = 0; c < 8; c++) cycle(c % N, "rr_all");

        req_vld[0] = 1'b0; req_vld[2] = 1'b0;
        cycle(1, "rr_13"); cycle(3, "rr_13"); cycle(1, "rr_13"); cycle(3, "rr_13");

        clear_all();
        set_req(2, 1'b1, 9'h005, {16{8'hA5}}, '1);
        cycle(2, "wr2");
        set_req(2, 1'b0, 9'h005, '0, '0);
        cycle(2, "rd2");
        clear_all();
        cycle(-1, "idle");

        set_req(1, 1'b1, 9'h010, 128'h00112233_44556677_8899AABB_CCDDEEFF, '1);
        cycle(1, "be_full");
        set_req(1, 1'b1, 9'h010, '0, 16'h0001);
        cycle(1, "be_low");
        set_req(1, 1'b0, 9'h010, '0, '0);
        cycle(1, "be_rd");
        clear_all();
        cycle(-1, "idle");
        chk("be_const", 256'(exp_mem[9'h010]), 256'(128'h00112233_44556677_8899AABB_CCDDEE00));

        // ptr is now 2; a lone request from 0 wins and ptr must move to 1.
        set_req(0, 1'b0, 9'h010, '0, '0);
        cycle(0, "skip");
        set_req(1, 1'b0, 9'h005, '0, '0);
        set_req(2, 1'b0, 9'h1FF, '0, '0);
        set_req(3, 1'b0, 9'h010, '0, '0);
        cycle(1, "after_skip");
        cycle(2, "after_skip");
        clear_all();
        set_req(3, 1'b1, 9'h010, {DW{1'b1}}, '0);
        cycle(3, "wbe0");
        set_req(3, 1'b0, 9'h010, '0, '0);
        cycle(3, "wbe0_rd");
        clear_all();
        cycle(-1, "idle");

        // Reset right after a read grant: the response must never appear.
        set_req(0, 1'b0, 9'h005, '0, '0);
        #1 chk("rst_run_grant", 256'(req_rdy), 256'(4'b0001));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_run_rsp", 256'({rsp_vld, mem_en, init_done}), 256'(0));
        @(negedge clk);
        #1 chk("rst_run_rsp_hold", 256'(rsp_vld), 256'(1'b0));
        clear_all();
        rst_n = 1'b1;
        #1 chk_init("reinit_start", 0);
        for (int c = 0; c < 600 && !init_done; c++) @(negedge clk);
        chk("reinit_done", 256'(init_done), 256'(1'b1));
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        set_req(0, 1'b0, 9'h010, '0, '0);
        cycle(0, "post_reinit_rd");
        clear_all();
        cycle(-1, "idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
